// File: rtl/axi_tensor_rd.sv
// Purpose: AXI4 read master; fetches one operand tile (one burst) and scatters it into the 8x8 PE tile buffer.
// Latency: rd_enb to rd_done is 2 + beats cycles minimum (34 normal, 18 FP16 special).
// Backpressure: arvalid is held until arready; rvalid gaps stall the counters and leave the buffer untouched.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   mixed, rd_enb, addr_type,   start controls; mode, datatype and address are sampled when
//   rd_addr                     rd_enb is taken in IDLE
//   axi_ar*                     read address channel (one INCR burst of 256-bit beats)
//   axi_r*                      read data channel
//   rd_buf                      tile buffer [pe_row][pe_col][127:0]
//   busy, rd_done, rd_err       status to the controller

package params;
  typedef enum logic [1:0] {
    INT8  = 2'd0,
    INT16 = 2'd1,
    FP16  = 2'd2,
    FP32  = 2'd3
  } dtype_t;

  typedef struct packed {
    dtype_t datatype;
  } addrgen_t;
endpackage

module axi_tensor_rd #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mixed,
  input  logic                      rd_enb,
  input  params::addrgen_t          addr_type,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  output logic [ADDR_WIDTH-1:0]     axi_araddr,
  output logic [7:0]                axi_arlen,
  output logic [2:0]                axi_arsize,
  output logic [1:0]                axi_arburst,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  input  logic [255:0]              axi_rdata,
  input  logic [1:0]                axi_rresp,
  input  logic                      axi_rlast,
  output logic [7:0][7:0][127:0]    rd_buf,
  output logic                      busy,
  output logic                      rd_done,
  output logic                      rd_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic                     r_special;
  logic [ADDR_WIDTH-1:0]    r_araddr;
  logic [4:0]               r_beat_cnt;
  logic [2:0]               r_pe_row;
  logic [1:0]               r_wave;
  logic [7:0][7:0][127:0]   r_buf;
  logic                     r_done;
  logic                     r_err;

  logic                     w_start;
  logic                     w_special_in;
  logic                     w_r_hs;
  logic [4:0]               w_last_idx;
  logic                     w_is_last;
  logic                     w_end;
  logic                     w_beat_err;

  assign w_start      = (r_state == S_IDLE) && rd_enb;
  assign w_special_in = ~mixed && (addr_type.datatype == params::FP16);
  assign w_r_hs       = (r_state == S_DATA) && axi_rvalid;
  assign w_last_idx   = r_special ? 5'd15 : 5'd31;
  assign w_is_last    = (r_beat_cnt == w_last_idx);
  // Early rlast terminates the burst; a missing rlast on the final beat still ends normally.
  assign w_end        = w_r_hs && (w_is_last || axi_rlast);
  // Any bad response, early rlast or missing final rlast marks the transfer as failed.
  assign w_beat_err   = (axi_rresp != 2'b00) || (axi_rlast != w_is_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rd_enb) begin
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        axi_arvalid = 1'b1;
        busy        = 1'b1;
        if (axi_arready) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        axi_rready = 1'b1;
        busy       = 1'b1;
        if (w_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_special  <= 1'b0;
      r_araddr   <= '0;
      r_beat_cnt <= '0;
      r_pe_row   <= '0;
      r_wave     <= '0;
      r_buf      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_special  <= w_special_in;
        r_araddr   <= rd_addr;
        r_beat_cnt <= '0;
        r_pe_row   <= '0;
        r_wave     <= '0;
        r_buf      <= '0;
        r_err      <= 1'b0;
      end else if (w_r_hs) begin
        for (int i = 0; i < 8; i++) begin
          if (!r_special) begin
            r_buf[r_pe_row][i][{r_wave, 5'd0} +: 32] <= axi_rdata[i*32 +: 32];
          end else begin
            // FP16 halves land in the low 16 bits of two consecutive 32-bit lanes;
            // wave 0 uses lanes 0/1, wave 1 uses lanes 2/3.
            r_buf[r_pe_row][i][{r_wave[0], 6'd0}  +: 16] <= axi_rdata[i*32      +: 16];
            r_buf[r_pe_row][i][{r_wave[0], 6'd32} +: 16] <= axi_rdata[i*32 + 16 +: 16];
          end
        end
        r_beat_cnt <= r_beat_cnt + 5'd1;
        r_pe_row   <= r_pe_row + 3'd1;
        if (r_pe_row == 3'd7) begin
          r_wave <= r_wave + 2'd1;
        end
        if (w_beat_err) begin
          r_err <= 1'b1;
        end
        if (w_end) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign axi_araddr  = r_araddr;
  assign axi_arlen   = r_special ? 8'd15 : 8'd31;
  assign axi_arsize  = 3'b101;
  assign axi_arburst = 2'b01;
  assign rd_buf      = r_buf;
  assign rd_done     = r_done;
  assign rd_err      = r_err;

endmodule
